counter_bus_ctrl: RTL and testbench

//  Synchronous controller for the AVR multiplexed bus (ale/rd/wr/ad) in front of
//  the four encoder counters. Synchronises the bus strobes, latches the address,

---
 rtl/counter_bus_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_counter_bus_ctrl.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_bus_ctrl.sv
// ---------------------------------------------------------------------------
// counter_bus_ctrl
//
// Purpose:
//   Synchronous controller for the AVR multiplexed bus (ale/rd/wr/ad) sitting
//   in front of four encoder counters. The asynchronous bus pins are brought
//   into the clk domain through 2-flop synchronisers. An address is latched
//   while ale is high. A read strobe returns a counter snapshot or the enable
//   register. A write strobe updates the counter enables or issues a one-cycle
//   clear pulse.
//
// Ports:
//   clk      in   1        system clock, rising edge
//   rst      in   1        synchronous reset, active-high
//   ale      in   1        address latch enable (async, active-high)
//   rd       in   1        read strobe (async, active-low)
//   wr       in   1        write strobe (async, active-low)
//   ad_in    in   size     ad pad input value (async)
//   ad_out   out  size     data driven onto ad while ad_oe=1
//   ad_oe    out  1        ad output enable
//   counts   in   4*size   live counters, counter n at [n*size +: size]
//   cnt_en   out  4        per-counter enable
//   cnt_clr  out  4        one-cycle clear pulse per counter
//
// The read/write maps use bits [7:0] of the data path, so size must be >= 8.
// ---------------------------------------------------------------------------
module counter_bus_ctrl #(
  parameter int size    = 8,
  parameter int timeout = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ale,
  input  logic              rd,
  input  logic              wr,
  input  logic [size-1:0]   ad_in,
  output logic [size-1:0]   ad_out,
  output logic              ad_oe,
  input  logic [4*size-1:0] counts,
  output logic [3:0]        cnt_en,
  output logic [3:0]        cnt_clr
);

  localparam int TW = (timeout > 1) ? $clog2(timeout) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, READ, WRITE} state_t;

  // Two-flop synchronisers. Bit 1 is the synchronised value. Idle levels
  // (ale low, strobes high) are restored on reset so no strobe edge is seen
  // when reset is released.
  logic [1:0]      ale_sync_q, rd_sync_q, wr_sync_q;
  logic [size-1:0] ad_meta_q, ad_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ale_sync_q <= 2'b00;
      rd_sync_q  <= 2'b11;
      wr_sync_q  <= 2'b11;
      ad_meta_q  <= '0;
      ad_sync_q  <= '0;
    end else begin
      ale_sync_q <= {ale_sync_q[0], ale};
      rd_sync_q  <= {rd_sync_q[0], rd};
      wr_sync_q  <= {wr_sync_q[0], wr};
      ad_meta_q  <= ad_in;
      ad_sync_q  <= ad_meta_q;
    end
  end

  logic ale_s, rd_s, wr_s;
  assign ale_s = ale_sync_q[1];
  assign rd_s  = rd_sync_q[1];
  assign wr_s  = wr_sync_q[1];

  state_t                 state_q, state_d;
  logic [2:0]             addr_q, addr_d;
  logic [TW-1:0]          timer_q, timer_d;
  // Snapshots of counters 1..3. Counter 0 is returned live at the moment the
  // snapshot is taken, so it needs no storage of its own.
  logic [3:1][size-1:0]   snap_q, snap_d;
  logic [size-1:0]        ad_out_q, ad_out_d;
  logic                   ad_oe_q, ad_oe_d;
  logic [size-1:0]        wdata_q, wdata_d;
  logic [3:0]             cnt_en_q, cnt_en_d;
  logic [3:0]             cnt_clr_q, cnt_clr_d;
  logic [size-1:0]        rdata;

  // Read mux, evaluated against the latched address at READ entry.
  always_comb begin
    rdata = '0;
    case (addr_q)
      3'd0:    rdata = counts[size-1:0];
      3'd1:    rdata = snap_q[1];
      3'd2:    rdata = snap_q[2];
      3'd3:    rdata = snap_q[3];
      3'd4:    rdata[7:0] = {cnt_en_q, 4'b0000};
      default: rdata = '0;
    endcase
  end

  // Bus FSM. A new ale always wins over a pending strobe in READ/WRITE so a
  // fresh address cycle aborts the current one without committing anything.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    timer_d   = timer_q;
    snap_d    = snap_q;
    ad_out_d  = ad_out_q;
    ad_oe_d   = ad_oe_q;
    wdata_d   = wdata_q;
    cnt_en_d  = cnt_en_q;
    cnt_clr_d = '0;

    case (state_q)
      IDLE: begin
        if (ale_s) begin
          state_d = ADDR;
          addr_d  = ad_sync_q[2:0];
        end
      end

      ADDR: begin
        if (ale_s) begin
          addr_d = ad_sync_q[2:0];
        end else begin
          state_d = WAIT;
          timer_d = '0;
        end
      end

      WAIT: begin
        timer_d = timer_q + 1'b1;
        if (!rd_s && wr_s) begin
          state_d  = READ;
          ad_oe_d  = 1'b1;
          ad_out_d = rdata;
          if (addr_q == 3'd0) begin
            snap_d = counts[4*size-1:size];
          end
        end else if (!wr_s && rd_s) begin
          state_d = WRITE;
          wdata_d = ad_sync_q;
        end else if (ale_s) begin
          state_d = ADDR;
          addr_d  = ad_sync_q[2:0];
        end else if (timer_q == TW'(timeout - 1)) begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (ale_s) begin
          state_d = ADDR;
          addr_d  = ad_sync_q[2:0];
          ad_oe_d = 1'b0;
        end else if (rd_s) begin
          state_d = IDLE;
          ad_oe_d = 1'b0;
        end
      end

      WRITE: begin
        if (ale_s) begin
          state_d = ADDR;
          addr_d  = ad_sync_q[2:0];
        end else if (wr_s) begin
          state_d = IDLE;
          if (addr_q == 3'd4) begin
            cnt_en_d = wdata_q[7:4];
          end else if (addr_q == 3'd5) begin
            cnt_clr_d = wdata_q[3:0];
          end
        end else begin
          wdata_d = ad_sync_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      timer_q   <= '0;
      snap_q    <= '0;
      ad_out_q  <= '0;
      ad_oe_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_en_q  <= 4'hF;
      cnt_clr_q <= 4'h0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      timer_q   <= timer_d;
      snap_q    <= snap_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
      wdata_q   <= wdata_d;
      cnt_en_q  <= cnt_en_d;
      cnt_clr_q <= cnt_clr_d;
    end
  end

  assign ad_out  = ad_out_q;
  assign ad_oe   = ad_oe_q;
  assign cnt_en  = cnt_en_q;
  assign cnt_clr = cnt_clr_q;

endmodule

// File: tb/tb_counter_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_bus_ctrl
//
// Purpose:
//   Directed testbench for counter_bus_ctrl. Bus pins are driven on the
//   falling clock edge and DUT outputs are sampled on falling edges, well away
//   from the rising edge where the DUT updates.
// ---------------------------------------------------------------------------
module tb_counter_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        ale;
  logic        rd;
  logic        wr;
  logic [7:0]  ad_in;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [31:0] counts;
  logic [3:0]  cnt_en;
  logic [3:0]  cnt_clr;

  int checks;
  int errors;

  counter_bus_ctrl #(.size(8), .timeout(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .ale     (ale),
    .rd      (rd),
    .wr      (wr),
    .ad_in   (ad_in),
    .ad_out  (ad_out),
    .ad_oe   (ad_oe),
    .counts  (counts),
    .cnt_en  (cnt_en),
    .cnt_clr (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address phase: ale high for 3 clocks with the address on ad, then ale low
  // long enough for the synchronised ale to fall and the FSM to reach WAIT.
  task automatic bus_addr(input logic [2:0] a);
    @(negedge clk);
    ad_in = {5'b00000, a};
    ale   = 1'b1;
    repeat (3) @(negedge clk);
    ale = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Complete read cycle. Data and enable are sampled while rd is still low.
  task automatic do_read(input logic [2:0] a, output logic [7:0] d,
                         output logic oe);
    bus_addr(a);
    @(negedge clk);
    rd = 1'b0;
    repeat (4) @(negedge clk);
    d  = ad_out;
    oe = ad_oe;
    @(negedge clk);
    rd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Complete write cycle. Afterwards reports how many cycles cnt_clr was
  // non-zero, its value, and on which falling edge after wr rose it appeared.
  task automatic do_write(input logic [2:0] a, input logic [7:0] d,
                          output int pulses, output logic [3:0] clr_val,
                          output int first);
    pulses  = 0;
    clr_val = 4'h0;
    first   = 0;
    bus_addr(a);
    @(negedge clk);
    ad_in = d;
    wr    = 1'b0;
    repeat (4) @(negedge clk);
    wr = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (cnt_clr != 4'h0) begin
        pulses++;
        clr_val = cnt_clr;
        if (first == 0) first = i;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ad_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_oe: got %b expected 0", ad_oe);
    end
    checks++;
    if (ad_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_ad_out: got %h expected 00", ad_out);
    end
    checks++;
    if (cnt_en !== 4'hF) begin
      errors++;
      $display("[TB] FAIL reset_cnt_en: got %h expected f", cnt_en);
    end
    checks++;
    if (cnt_clr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt_clr: got %h expected 0", cnt_clr);
    end
  endtask

  // Read of addr 0 with exact enable timing relative to the rd pin.
  task automatic test_read_timing();
    counts = {8'd40, 8'd30, 8'd20, 8'd10};
    bus_addr(3'd0);
    @(negedge clk);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ad_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_oe_early: got %b expected 0", ad_oe);
    end
    @(negedge clk);
    checks++;
    if (ad_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_oe_on: got %b expected 1", ad_oe);
    end
    checks++;
    if (ad_out !== 8'h0A) begin
      errors++;
      $display("[TB] FAIL read_data0: got %h expected 0a", ad_out);
    end
    counts = {8'd77, 8'd66, 8'd55, 8'd44};
    repeat (7) @(negedge clk);
    checks++;
    if (ad_out !== 8'h0A) begin
      errors++;
      $display("[TB] FAIL read_stable: got %h expected 0a", ad_out);
    end
    rd = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ad_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_oe_hold: got %b expected 1", ad_oe);
    end
    @(negedge clk);
    checks++;
    if (ad_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL read_oe_off: got %b expected 0", ad_oe);
    end
    repeat (3) @(negedge clk);
  endtask

  // Addresses 1..3 return the snapshot taken by the last addr-0 read.
  task automatic test_snapshot();
    logic [7:0] d;
    logic       oe;
    counts = {8'd4, 8'd3, 8'd2, 8'd1};
    do_read(3'd0, d, oe);
    checks++;
    if (d !== 8'h01 || oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL snap_read0: got %h/%b expected 01/1", d, oe);
    end
    counts = {8'd9, 8'd9, 8'd9, 8'd9};
    do_read(3'd1, d, oe);
    checks++;
    if (d !== 8'h02) begin
      errors++;
      $display("[TB] FAIL snap_read1: got %h expected 02", d);
    end
    do_read(3'd2, d, oe);
    checks++;
    if (d !== 8'h03) begin
      errors++;
      $display("[TB] FAIL snap_read2: got %h expected 03", d);
    end
    do_read(3'd3, d, oe);
    checks++;
    if (d !== 8'h04) begin
      errors++;
      $display("[TB] FAIL snap_read3: got %h expected 04", d);
    end
    do_read(3'd0, d, oe);
    checks++;
    if (d !== 8'h09) begin
      errors++;
      $display("[TB] FAIL snap_reread0: got %h expected 09", d);
    end
    counts = {8'd4, 8'd3, 8'd2, 8'd1};
    do_read(3'd1, d, oe);
    checks++;
    if (d !== 8'h09) begin
      errors++;
      $display("[TB] FAIL snap_reread1: got %h expected 09", d);
    end
    do_read(3'd6, d, oe);
    checks++;
    if (d !== 8'h00) begin
      errors++;
      $display("[TB] FAIL read_addr6: got %h expected 00", d);
    end
  endtask

  task automatic test_write();
    int         pulses;
    int         first;
    logic [3:0] clr_val;
    logic [7:0] d;
    logic       oe;
    do_write(3'd5, 8'h05, pulses, clr_val, first);
    checks++;
    if (pulses !== 1 || clr_val !== 4'b0101) begin
      errors++;
      $display("[TB] FAIL clr_pulse: got %0d cycles of %b expected 1 of 0101",
               pulses, clr_val);
    end
    checks++;
    if (first !== 3) begin
      errors++;
      $display("[TB] FAIL clr_latency: got edge %0d expected 3", first);
    end
    checks++;
    if (cnt_en !== 4'hF) begin
      errors++;
      $display("[TB] FAIL clr_keeps_en: got %h expected f", cnt_en);
    end
    do_write(3'd4, 8'h30, pulses, clr_val, first);
    checks++;
    if (cnt_en !== 4'h3 || pulses !== 0) begin
      errors++;
      $display("[TB] FAIL en_write: got %h/%0d expected 3/0", cnt_en, pulses);
    end
    do_write(3'd6, 8'hFF, pulses, clr_val, first);
    checks++;
    if (cnt_en !== 4'h3 || pulses !== 0) begin
      errors++;
      $display("[TB] FAIL ignored_write: got %h/%0d expected 3/0", cnt_en, pulses);
    end
    do_read(3'd4, d, oe);
    checks++;
    if (d !== 8'h30 || oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL read_en: got %h/%b expected 30/1", d, oe);
    end
    do_read(3'd1, d, oe);
    checks++;
    if (d !== 8'h09) begin
      errors++;
      $display("[TB] FAIL snap_after_clr: got %h expected 09", d);
    end
  endtask

  // A strobe shortly before the timeout is served; one after it is ignored.
  task automatic test_timeout();
    logic seen_oe;
    bus_addr(3'd4);
    repeat (58) @(negedge clk);
    rd = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ad_oe !== 1'b1 || ad_out !== 8'h30) begin
      errors++;
      $display("[TB] FAIL in_window_read: got %b/%h expected 1/30", ad_oe, ad_out);
    end
    @(negedge clk);
    rd = 1'b1;
    repeat (4) @(negedge clk);
    bus_addr(3'd4);
    repeat (66) @(negedge clk);
    rd = 1'b0;
    seen_oe = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ad_oe) seen_oe = 1'b1;
    end
    checks++;
    if (seen_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_no_oe: got %b expected 0", seen_oe);
    end
    rd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_protocol_error();
    logic seen_oe;
    logic seen_clr;
    bus_addr(3'd4);
    @(negedge clk);
    ad_in    = 8'h00;
    rd       = 1'b0;
    wr       = 1'b0;
    seen_oe  = 1'b0;
    seen_clr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ad_oe) seen_oe = 1'b1;
    end
    rd = 1'b1;
    wr = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (cnt_clr != 4'h0) seen_clr = 1'b1;
    end
    checks++;
    if (seen_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL both_low_oe: got %b expected 0", seen_oe);
    end
    checks++;
    if (cnt_en !== 4'h3 || seen_clr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL both_low_commit: got %h/%b expected 3/0", cnt_en, seen_clr);
    end
  endtask

  task automatic test_ale_abort();
    bus_addr(3'd1);
    @(negedge clk);
    rd = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ad_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre_oe: got %b expected 1", ad_oe);
    end
    ad_in = 8'h02;
    ale   = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ad_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ale_abort: got %b expected 0", ad_oe);
    end
    rd = 1'b1;
    repeat (3) @(negedge clk);
    ale = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_in_read();
    bus_addr(3'd0);
    @(negedge clk);
    rd = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (ad_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre_oe: got %b expected 1", ad_oe);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ad_oe !== 1'b0 || ad_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rst_read_oe: got %b/%h expected 0/00", ad_oe, ad_out);
    end
    checks++;
    if (cnt_en !== 4'hF || cnt_clr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL rst_read_ctrl: got %h/%h expected f/0", cnt_en, cnt_clr);
    end
    rst = 1'b0;
    rd  = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Sequence of scenario tasks followed by the summary line.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    ale    = 1'b0;
    rd     = 1'b1;
    wr     = 1'b1;
    ad_in  = 8'h00;
    counts = 32'h0;
    $display("[TB] starting counter_bus_ctrl bench");
    test_reset();
    test_read_timing();
    test_snapshot();
    test_write();
    test_timeout();
    test_protocol_error();
    test_ale_abort();
    test_reset_in_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
